// File: rtl/logu_serial_seq.sv
// logu_serial_seq
//   Bit-serial sequencer in front of a 1-bit logic unit (LogU). A WIDTH-bit
//   logic operation is performed by streaming operand bits LSB first through
//   LogU and reassembling its output into a WIDTH-bit result.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start / ready     request handshake (accepted only while ready=1)
//   a_in, b_in, opsel operands and op code (0 AND, 1 OR, 2 XOR, 3 NOT A)
//   lu_a, lu_b        operand bits to LogU
//   lu_opsel0..2      latched op code bits to LogU
//   lu_out            LogU output (combinational from lu_*)
//   result, err       assembled result / illegal op flag, valid with done
//   done              one-cycle completion pulse
module logu_serial_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [2:0]       opsel,
    output logic             lu_a,
    output logic             lu_b,
    output logic             lu_opsel0,
    output logic             lu_opsel1,
    output logic             lu_opsel2,
    input  logic             lu_out,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       op_q,     op_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             err_q,    err_d;

    // Captured bit enters at the MSB so that after WIDTH captures the first
    // (LSB) bit has walked down to bit 0.
    logic [WIDTH-1:0] res_next;
    assign res_next = {lu_out, res_sh_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        result_d = result_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (opsel[2]) begin
                        err_d    = 1'b1;
                        result_d = '0;
                        state_d  = S_DONE;
                    end else begin
                        a_sh_d   = a_in;
                        b_sh_d   = b_in;
                        op_d     = opsel;
                        cnt_d    = '0;
                        res_sh_d = '0;
                        result_d = '0;
                        err_d    = 1'b0;
                        state_d  = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                res_sh_d = res_next;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    result_d = res_next;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            result_q <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            result_q <= result_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // LogU is only driven while shifting; all lu_* sit at 0 otherwise.
    logic in_shift;
    assign in_shift  = (state_q == S_SHIFT);
    assign lu_a      = in_shift & a_sh_q[0];
    assign lu_b      = in_shift & b_sh_q[0];
    assign lu_opsel0 = in_shift & op_q[0];
    assign lu_opsel1 = in_shift & op_q[1];
    assign lu_opsel2 = in_shift & op_q[2];

    assign ready  = (state_q == S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign err    = err_q;

endmodule
